// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
package mc_ctrl_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned FLAG_W  = 4;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI,
      MULEX, ALUWB, BRANCH, FPEX, FPWB
   } state_t;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_ORR   = 3'b011;
   localparam logic [2:0] ALU_MUL   = 3'b100;
   localparam logic [2:0] ALU_UMULL = 3'b101;
   localparam logic [2:0] ALU_SMULL = 3'b110;
   localparam logic [2:0] ALU_EOR   = 3'b111;

   localparam logic [1:0] SRCA_REG   = 2'b00;
   localparam logic [1:0] SRCA_PC    = 2'b01;
   localparam logic [1:0] SRCB_WD    = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] IMM_8      = 2'b00;
   localparam logic [1:0] IMM_12     = 2'b01;
   localparam logic [1:0] IMM_24     = 2'b10;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/cond_unit.sv
// NZCV flags register with per-group write masking and ARM condition evaluation.
module cond_unit
   import mc_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        cond,
   input  logic [FLAG_W-1:0] alu_flags,
   input  logic [1:0]        flag_we,
   output logic              cond_ex_c
);

   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              n, z, c, v;

   // flag_we[1] covers N,Z; flag_we[0] covers C,V
   always_comb begin
      flags_d = flags_q;
      if (flag_we[1]) flags_d[3:2] = alu_flags[3:2];
      if (flag_we[0]) flags_d[1:0] = alu_flags[1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= '0;
      else        flags_q <= flags_d;
   end

   assign {n, z, c, v} = flags_q;

   always_comb begin
      cond_ex_c = 1'b0;
      case (cond)
         COND_EQ: cond_ex_c = z;
         COND_NE: cond_ex_c = !z;
         COND_CS: cond_ex_c = c;
         COND_CC: cond_ex_c = !c;
         COND_MI: cond_ex_c = n;
         COND_PL: cond_ex_c = !n;
         COND_VS: cond_ex_c = v;
         COND_VC: cond_ex_c = !v;
         COND_HI: cond_ex_c = c && !z;
         COND_LS: cond_ex_c = !c || z;
         COND_GE: cond_ex_c = (n == v);
         COND_LT: cond_ex_c = (n != v);
         COND_GT: cond_ex_c = !z && (n == v);
         COND_LE: cond_ex_c = z || (n != v);
         COND_AL: cond_ex_c = 1'b1;
         default: cond_ex_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: instruction decoder and sequencing FSM driving the datapath.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned RESET_PC_FETCH = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] Instr,
   input  logic [FLAG_W-1:0]  ALUFlags,
   output logic               PCWrite,
   output logic               RegWrite,
   output logic               IRWrite,
   output logic               FPUWrite,
   output logic               MemWrite,
   output logic               AdrSrc,
   output logic [1:0]         RegSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ImmSrc,
   output logic [2:0]         ALUControl,
   output logic               LongFlag
);

   if (RESET_PC_FETCH != 1) begin : g_bad_reset_cfg
      $error("mc_control_fsm: only RESET_PC_FETCH = 1 is supported");
   end

   state_t     state_q, state_d;
   logic [3:0] opcode;
   logic       is_mul, is_dp, is_mem, is_branch, is_fp, is_load, is_store;
   logic       dp_ok, dp_arith, is_cmp, op_valid, cond_ex;
   logic [2:0] dp_alu;
   logic [1:0] flag_we;
   logic       pc_we, reg_we, ir_we, fpu_we, mem_we;
   logic       unused_instr;

   assign unused_instr = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

   assign opcode    = Instr[24:21];
   assign is_mul    = (Instr[27:26] == 2'b00) && !Instr[25] && (Instr[7:4] == 4'b1001);
   assign is_dp     = (Instr[27:26] == 2'b00) && !is_mul;
   assign is_mem    = (Instr[27:26] == 2'b01);
   assign is_branch = (Instr[27:26] == 2'b10);
   assign is_fp     = (Instr[27:24] == 4'b1110);
   assign is_load   = is_mem && Instr[20];
   assign is_store  = is_mem && !Instr[20];
   assign is_cmp    = (opcode == OP_CMP);
   assign dp_arith  = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_CMP);

   always_comb begin
      dp_ok  = 1'b1;
      dp_alu = ALU_ADD;
      case (opcode)
         OP_ADD:  dp_alu = ALU_ADD;
         OP_SUB:  dp_alu = ALU_SUB;
         OP_CMP:  dp_alu = ALU_SUB;
         OP_AND:  dp_alu = ALU_AND;
         OP_ORR:  dp_alu = ALU_ORR;
         OP_EOR:  dp_alu = ALU_EOR;
         default: dp_ok  = 1'b0;
      endcase
   end

   // Unlisted data-processing opcodes fall into the undefined/NOP path
   assign op_valid = is_mul || (is_dp && dp_ok) || is_mem || is_branch || is_fp;

   cond_unit u_cond (
      .clk       (clk),
      .rst_n     (reset),
      .cond      (Instr[31:28]),
      .alu_flags (ALUFlags),
      .flag_we   (flag_we),
      .cond_ex_c (cond_ex)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            if (!cond_ex || !op_valid) state_d = FETCH;
            else if (is_mem)           state_d = MEMADR;
            else if (is_branch)        state_d = BRANCH;
            else if (is_fp)            state_d = FPEX;
            else if (is_mul)           state_d = MULEX;
            else if (Instr[25])        state_d = EXECI;
            else                       state_d = EXECR;
         end
         MEMADR: state_d = is_load ? MEMRD : MEMWR;
         MEMRD:  state_d = MEMWB;
         EXECR,
         EXECI:  state_d = is_cmp ? FETCH : ALUWB;
         MULEX:  state_d = ALUWB;
         FPEX:   state_d = FPWB;
         default: state_d = FETCH;
      endcase
   end

   // Moore-style decode of selects and raw enables
   always_comb begin
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      ir_we      = 1'b0;
      fpu_we     = 1'b0;
      mem_we     = 1'b0;
      AdrSrc     = 1'b0;
      RegSrc     = 2'b00;
      ALUSrcA    = SRCA_REG;
      ALUSrcB    = SRCB_WD;
      ResultSrc  = RES_ALUOUT;
      ImmSrc     = IMM_8;
      ALUControl = ALU_ADD;
      LongFlag   = 1'b0;
      flag_we    = 2'b00;
      case (state_q)
         FETCH: begin
            ir_we = 1'b1; pc_we = 1'b1;
            ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES;
         end
         DECODE: begin
            ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES;
            RegSrc  = {is_store, is_branch};
         end
         MEMADR: begin
            ALUSrcB = SRCB_IMM; ImmSrc = IMM_12;
         end
         MEMRD: AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = RES_DATA; reg_we = 1'b1;
         end
         MEMWR: begin
            AdrSrc = 1'b1; mem_we = 1'b1;
         end
         EXECR, EXECI: begin
            ALUSrcB    = (state_q == EXECI) ? SRCB_IMM : SRCB_WD;
            ALUControl = dp_alu;
            flag_we    = Instr[20] ? {1'b1, dp_arith} : 2'b00;
         end
         MULEX: begin
            ALUControl = !Instr[23] ? ALU_MUL : (Instr[22] ? ALU_SMULL : ALU_UMULL);
            flag_we    = {Instr[20], 1'b0};
         end
         ALUWB: begin
            reg_we   = 1'b1;
            LongFlag = is_mul && Instr[23];
            pc_we    = !is_mul && (Instr[15:12] == 4'hF);
         end
         BRANCH: begin
            ALUSrcB = SRCB_IMM; ImmSrc = IMM_24; ResultSrc = RES_ALURES; pc_we = 1'b1;
         end
         FPWB: fpu_we = 1'b1;
         default: ;
      endcase
   end

   // Reset suppresses every write immediately, independent of the clock
   assign PCWrite  = pc_we  && reset;
   assign RegWrite = reg_we && reset;
   assign IRWrite  = ir_we  && reset;
   assign FPUWrite = fpu_we && reset;
   assign MemWrite = mem_we && reset;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: directed instructions, per-cycle expected control vectors.
module tb_mc_control_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, RegWrite, IRWrite, FPUWrite, MemWrite, AdrSrc, LongFlag;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0]  ALUControl;

   int total = 0;
   int bad   = 0;

   logic [19:0] exp_q[$];
   string       name_q[$];

   mc_control_fsm #(.RESET_PC_FETCH(1)) dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite), .FPUWrite(FPUWrite),
      .MemWrite(MemWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .LongFlag(LongFlag)
   );

   always #5 clk = ~clk;

   // {PCW,RegW,IRW,FPUW,MemW,AdrSrc,RegSrc,SrcA,SrcB,ResSrc,ImmSrc,ALUCtl,Long}
   function automatic logic [19:0] mk(input logic pcw, input logic rw, input logic irw,
                                      input logic fw, input logic mw, input logic adr,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] res,
                                      input logic [1:0] imm, input logic [2:0] alu,
                                      input logic lng);
      return {pcw, rw, irw, fw, mw, adr, rs, sa, sb, res, imm, alu, lng};
   endfunction

   function automatic logic [19:0] v_fetch();
      return mk(1,0,1,0,0,0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 3'b000, 0);
   endfunction
   function automatic logic [19:0] v_rst();
      return mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 3'b000, 0);
   endfunction
   function automatic logic [19:0] v_dec(input logic [1:0] rs);
      return mk(0,0,0,0,0,0, rs, 2'b01, 2'b10, 2'b10, 2'b00, 3'b000, 0);
   endfunction
   function automatic logic [19:0] v_execr(input logic [2:0] a);
      return mk(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, a, 0);
   endfunction
   function automatic logic [19:0] v_execi(input logic [2:0] a);
      return mk(0,0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, a, 0);
   endfunction
   function automatic logic [19:0] v_aluwb(input logic pcw, input logic lng);
      return mk(pcw,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, lng);
   endfunction
   function automatic logic [19:0] v_memadr();
      return mk(0,0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 3'b000, 0);
   endfunction
   function automatic logic [19:0] v_memrd();
      return mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
   endfunction
   function automatic logic [19:0] v_memwb();
      return mk(0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 0);
   endfunction
   function automatic logic [19:0] v_memwr();
      return mk(0,0,0,0,1,1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
   endfunction
   function automatic logic [19:0] v_branch();
      return mk(1,0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 3'b000, 0);
   endfunction
   function automatic logic [19:0] v_fpex();
      return mk(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
   endfunction
   function automatic logic [19:0] v_fpwb();
      return mk(0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
   endfunction

   task automatic expect_v(input logic [19:0] v, input string nm);
      exp_q.push_back(v);
      name_q.push_back(nm);
   endtask

   // Apply an instruction at the start of FETCH and let it run n cycles
   task automatic run(input logic [31:0] ins, input logic [3:0] af, input int n);
      Instr    = ins;
      ALUFlags = af;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: one expected vector per cycle, sampled mid-cycle
   always @(negedge clk) begin
      logic [19:0] act, e;
      string       nm;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {PCWrite, RegWrite, IRWrite, FPUWrite, MemWrite, AdrSrc, RegSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ImmSrc, ALUControl, LongFlag};
         total++;
         if (act !== e) begin
            bad++;
            $display("FAIL %s: got %05h want %05h", nm, act, e);
         end
      end
   end

   initial begin
      reset    = 1'b0;
      Instr    = 32'h0;
      ALUFlags = 4'h0;
      @(posedge clk); #1;
      expect_v(v_rst(), "reset.c1");
      expect_v(v_rst(), "reset.c2");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // ADD R1,R2,R3 without S: ALU flags must not be captured
      expect_v(v_fetch(), "add.fetch"); expect_v(v_dec(2'b00), "add.decode");
      expect_v(v_execr(3'b000), "add.execr"); expect_v(v_aluwb(0, 0), "add.aluwb");
      run(32'hE0821003, 4'hF, 4);

      // BEQ with Z clear: condition fails
      expect_v(v_fetch(), "beq0.fetch"); expect_v(v_dec(2'b01), "beq0.decode");
      run(32'h0A000002, 4'h0, 2);

      // SUBS capturing Z=1
      expect_v(v_fetch(), "subs.fetch"); expect_v(v_dec(2'b00), "subs.decode");
      expect_v(v_execr(3'b001), "subs.execr"); expect_v(v_aluwb(0, 0), "subs.aluwb");
      run(32'hE0521003, 4'h4, 4);

      expect_v(v_fetch(), "beq1.fetch"); expect_v(v_dec(2'b01), "beq1.decode");
      expect_v(v_branch(), "beq1.branch");
      run(32'h0A000002, 4'h0, 3);

      // LDR / STR
      expect_v(v_fetch(), "ldr.fetch"); expect_v(v_dec(2'b00), "ldr.decode");
      expect_v(v_memadr(), "ldr.memadr"); expect_v(v_memrd(), "ldr.memrd");
      expect_v(v_memwb(), "ldr.memwb");
      run(32'hE5921004, 4'h0, 5);

      expect_v(v_fetch(), "str.fetch"); expect_v(v_dec(2'b10), "str.decode");
      expect_v(v_memadr(), "str.memadr"); expect_v(v_memwr(), "str.memwr");
      run(32'hE5821004, 4'h0, 4);

      // UMULL / MUL
      expect_v(v_fetch(), "umull.fetch"); expect_v(v_dec(2'b00), "umull.decode");
      expect_v(v_execr(3'b101), "umull.mulex"); expect_v(v_aluwb(0, 1), "umull.aluwb");
      run(32'hE0810392, 4'h0, 4);

      expect_v(v_fetch(), "mul.fetch"); expect_v(v_dec(2'b00), "mul.decode");
      expect_v(v_execr(3'b100), "mul.mulex"); expect_v(v_aluwb(0, 0), "mul.aluwb");
      run(32'hE0010392, 4'h0, 4);

      // ADD with Rd = R15 also writes the PC
      expect_v(v_fetch(), "addpc.fetch"); expect_v(v_dec(2'b00), "addpc.decode");
      expect_v(v_execr(3'b000), "addpc.execr"); expect_v(v_aluwb(1, 0), "addpc.aluwb");
      run(32'hE082F003, 4'h0, 4);

      // CMP clears Z, no writeback
      expect_v(v_fetch(), "cmp.fetch"); expect_v(v_dec(2'b00), "cmp.decode");
      expect_v(v_execr(3'b001), "cmp.execr");
      run(32'hE1520003, 4'h0, 3);

      expect_v(v_fetch(), "beq2.fetch"); expect_v(v_dec(2'b01), "beq2.decode");
      run(32'h0A000002, 4'h0, 2);

      // ORRS immediate with ALUFlags=1111: only N,Z captured -> flags 1100
      expect_v(v_fetch(), "orrs.fetch"); expect_v(v_dec(2'b00), "orrs.decode");
      expect_v(v_execi(3'b011), "orrs.execi"); expect_v(v_aluwb(0, 0), "orrs.aluwb");
      run(32'hE3911001, 4'hF, 4);

      expect_v(v_fetch(), "bcs.fetch"); expect_v(v_dec(2'b01), "bcs.decode");
      run(32'h2A000002, 4'h0, 2);

      expect_v(v_fetch(), "beq3.fetch"); expect_v(v_dec(2'b01), "beq3.decode");
      expect_v(v_branch(), "beq3.branch");
      run(32'h0A000002, 4'h0, 3);

      // Never-condition and undefined class
      expect_v(v_fetch(), "nv.fetch"); expect_v(v_dec(2'b00), "nv.decode");
      run(32'hF0821003, 4'h0, 2);

      expect_v(v_fetch(), "undef.fetch"); expect_v(v_dec(2'b00), "undef.decode");
      run(32'hEF000000, 4'h0, 2);

      // FP op
      expect_v(v_fetch(), "fp.fetch"); expect_v(v_dec(2'b00), "fp.decode");
      expect_v(v_fpex(), "fp.fpex"); expect_v(v_fpwb(), "fp.fpwb");
      run(32'hEE012100, 4'h0, 4);

      // Set Z, then reset during FPEX
      expect_v(v_fetch(), "subs2.fetch"); expect_v(v_dec(2'b00), "subs2.decode");
      expect_v(v_execr(3'b001), "subs2.execr"); expect_v(v_aluwb(0, 0), "subs2.aluwb");
      run(32'hE0521003, 4'h4, 4);

      expect_v(v_fetch(), "fprst.fetch"); expect_v(v_dec(2'b00), "fprst.decode");
      run(32'hEE012100, 4'h0, 2);
      reset = 1'b0;
      expect_v(v_rst(), "fprst.rst1"); expect_v(v_rst(), "fprst.rst2");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Flags cleared by reset: BEQ must fail
      expect_v(v_fetch(), "beq4.fetch"); expect_v(v_dec(2'b01), "beq4.decode");
      run(32'h0A000002, 4'h0, 2);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
